// File: rtl/plot_sink.sv
// plot_sink: FIFO-buffered pixel-plot receiver issuing acknowledged framebuffer writes.
// Optional range clipping is enabled by defining PLOT_SINK_CLIP_EN; revision 1.0.
`default_nettype none
`timescale 1ns/1ps

module plot_sink #(
  parameter int FIFO_AW = 3,
  parameter int XMAX    = 159,
  parameter int YMAX    = 119
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  output logic        ready,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [2:0]  wr_data,
  input  logic        wr_ack,
  output logic        busy,
  output logic [7:0]  drop_count,
  output logic [15:0] write_count
);

  localparam int              c_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] c_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [17:0]        r_mem [c_DEPTH];
  logic [FIFO_AW:0]   r_wptr;
  logic [FIFO_AW:0]   r_rptr;
  logic               r_ready;
  logic               r_busy;
  logic               r_wr_en;
  logic [14:0]        r_wr_addr;
  logic [2:0]         r_wr_data;
  logic [7:0]         r_drop;
  logic [15:0]        r_wcnt;

  logic               w_push;
  logic               w_pop;
  logic               w_load;
  logic               w_done;
  logic               w_drop;
  logic               w_in_range;
  logic [FIFO_AW:0]   w_count;
  logic [FIFO_AW:0]   w_count_nxt;
  logic [17:0]        w_head;
  logic [7:0]         w_hx;
  logic [6:0]         w_hy;
  logic [2:0]         w_hc;
  logic [14:0]        w_addr;

  assign w_push      = plot & r_ready;
  assign w_count     = r_wptr - r_rptr;
  assign w_count_nxt = w_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

  assign w_head = r_mem[r_rptr[FIFO_AW-1:0]];
  assign w_hx   = w_head[7:0];
  assign w_hy   = w_head[14:8];
  assign w_hc   = w_head[17:15];
  // y*160 as (y<<7)+(y<<5), all in 15 bits
  assign w_addr = ({8'd0, w_hy} << 7) + ({8'd0, w_hy} << 5) + {7'd0, w_hx};

`ifdef PLOT_SINK_CLIP_EN
  localparam logic [7:0] c_XMAX = 8'(XMAX);
  localparam logic [6:0] c_YMAX = 7'(YMAX);
  assign w_in_range = (w_hx <= c_XMAX) && (w_hy <= c_YMAX);
`else
  assign w_in_range = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_count != '0) begin
          w_pop = 1'b1;
          if (w_in_range) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (wr_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage carries no reset: pointers alone define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= {colour, y, x};
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_drop    <= '0;
      r_wcnt    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_ready <= (w_count_nxt != c_FULL);
      r_busy  <= (w_count_nxt != '0) || (w_state_nxt == S_ISSUE);
      if (w_load) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_addr;
        r_wr_data <= w_hc;
      end else if (w_done) begin
        r_wr_en <= 1'b0;
      end
      if (w_done) r_wcnt <= r_wcnt + 16'd1;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign drop_count  = r_drop;
  assign write_count = r_wcnt;

endmodule

`default_nettype wire

// File: tb/tb_plot_sink.sv
// tb_plot_sink: directed self-checking bench for plot_sink.
`default_nettype none
`timescale 1ns/1ps

module tb_plot_sink;

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ack;
  logic        busy;
  logic [7:0]  drop_count;
  logic [15:0] write_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          en_cycles = 0;
  logic [17:0] q_wr[$];

  plot_sink dut (
    .CLOCK_50    (CLOCK_50),
    .Reset       (Reset),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .ready       (ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .busy        (busy),
    .drop_count  (drop_count),
    .write_count (write_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Record every completed write as {data, addr}
  always @(posedge CLOCK_50) begin
    if (!Reset && wr_en) begin
      en_cycles++;
      if (wr_ack) q_wr.push_back({wr_data, wr_addr});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
    logic acc;
    logic ok;
    ok     = 1'b0;
    plot   = 1'b1;
    x      = xx;
    y      = yy;
    colour = cc;
    for (int i = 0; i < 100; i++) begin
      acc = ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    plot = 1'b0;
    check("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && !wr_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    plot = 1'b0; x = '0; y = '0; colour = '0; wr_ack = 1'b0; Reset = 1'b1;
    tick();
    tick();
    check("rst_ready", ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_wcount", write_count, 0);
    Reset = 1'b0;
    tick();
    check("rel_ready", ready, 1);

    // Single write, zero-wait ack
    wr_ack = 1'b1;
    q_wr.delete();
    plot = 1'b1; x = 8'd79; y = 7'd59; colour = 3'b101;
    tick();
    plot = 1'b0;
    check("t1_en_n", wr_en, 0);
    check("t1_busy_n", busy, 1);
    tick();
    check("t1_en_n1", wr_en, 1);
    check("t1_addr", wr_addr, 9519);
    check("t1_data", wr_data, 5);
    tick();
    check("t1_en_n2", wr_en, 0);
    check("t1_wcount", write_count, 1);
    check("t1_busy", busy, 0);
    check("t1_nwr", q_wr.size(), 1);

    // Stall: one entry in ISSUE plus 8 queued fills the FIFO
    wr_ack = 1'b0;
    q_wr.delete();
    for (int i = 0; i < 9; i++) send(8'(10*i + 1), 7'(i), 3'(i));
    check("t2_full", ready, 0);
    check("t2_en", wr_en, 1);
    check("t2_addr0", wr_addr, 1);
    plot = 1'b1; x = 8'd91; y = 7'd9; colour = 3'd1;
    tick(); tick(); tick();
    check("t2_hold_ready", ready, 0);
    check("t2_hold_en", wr_en, 1);
    wr_ack = 1'b1;
    send(8'd91, 7'd9, 3'd1);
    wait_idle("t2_idle");
    check("t2_nwr", q_wr.size(), 10);
    for (int i = 0; i < 10 && i < q_wr.size(); i++) begin
      check("t2_addr", {17'd0, q_wr[i][14:0]}, 170*i + 1);
      check("t2_data", {29'd0, q_wr[i][17:15]}, i % 8);
    end
    check("t2_wcount", write_count, 11);

`ifdef PLOT_SINK_CLIP_EN
    q_wr.delete();
    send(8'd160, 7'd0, 3'd1);
    send(8'd0, 7'd120, 3'd2);
    send(8'd159, 7'd119, 3'd6);
    wait_idle("t3_idle");
    check("t3_drop", drop_count, 2);
    check("t3_nwr", q_wr.size(), 1);
    if (q_wr.size() > 0) begin
      check("t3_addr", {17'd0, q_wr[0][14:0]}, 19199);
      check("t3_data", {29'd0, q_wr[0][17:15]}, 6);
    end
    check("t3_wcount", write_count, 12);
    en_cycles = 0;
    for (int i = 0; i < 300; i++) send(8'd200, 7'd5, 3'd3);
    wait_idle("t4_idle");
    check("t4_drop_sat", drop_count, 255);
    check("t4_no_wr", en_cycles, 0);
    check("t4_wcount", write_count, 12);
`else
    q_wr.delete();
    send(8'd200, 7'd0, 3'd4);
    send(8'd0, 7'd120, 3'd7);
    wait_idle("t6_idle");
    check("t6_nwr", q_wr.size(), 2);
    if (q_wr.size() > 1) begin
      check("t6_addr0", {17'd0, q_wr[0][14:0]}, 200);
      check("t6_data0", {29'd0, q_wr[0][17:15]}, 4);
      check("t6_addr1", {17'd0, q_wr[1][14:0]}, 19200);
      check("t6_data1", {29'd0, q_wr[1][17:15]}, 7);
    end
    check("t6_drop", drop_count, 0);
    check("t6_wcount", write_count, 13);
`endif

    // Reset mid-write with 4 entries queued
    wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(i + 1), 7'd1, 3'd1);
    check("t5_en", wr_en, 1);
    check("t5_addr", wr_addr, 161);
    #2 Reset = 1'b1;
    #1;
    check("t5_async_en", wr_en, 0);
    check("t5_wcount", write_count, 0);
    check("t5_drop", drop_count, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", ready, 0);
    tick();
    Reset = 1'b0;
    en_cycles = 0;
    q_wr.delete();
    tick();
    check("t5_rel_ready", ready, 1);
    wr_ack = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t5_no_stale", en_cycles, 0);
    check("t5_busy_after", busy, 0);
    check("t5_wcount_after", write_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
